// File: rtl/vec_dot_lanes_if.sv
// Operand/result bundle between the vector operand buffers (master) and the dot-product engine (slave).
interface vec_dot_lanes_if #(
  parameter int unsigned DIMENSION = 16,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 20
);
  logic                          start;
  logic [DIMENSION*WIDTH-1:0]    V1;
  logic [DIMENSION*WIDTH-1:0]    V2;
  logic                          ready;
  logic                          busy;
  logic                          done;
  logic signed [WIDTH-1:0]       VV;
  logic signed [ACC_WIDTH-1:0]   VV_full;
  logic                          sat;

  modport master (output start, V1, V2, input ready, busy, done, VV, VV_full, sat);
  modport slave  (input start, V1, V2, output ready, busy, done, VV, VV_full, sat);
endinterface

// File: rtl/vec_dot_lanes.sv
// Multi-lane signed dot-product engine: LANES MACs per cycle into one accumulator,
// then an arithmetic shift and signed clip down to a WIDTH-bit result.
module vec_dot_lanes #(
  parameter int unsigned DIMENSION = 16,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LANES     = 4,
  parameter int unsigned ACC_WIDTH = 20,
  parameter int unsigned OUT_SHIFT = 0
) (
  input  logic           clk,
  input  logic           rst,
  vec_dot_lanes_if.slave bus
);

  localparam int unsigned VEC_W    = DIMENSION * WIDTH;
  localparam int unsigned CHUNK_W  = LANES * WIDTH;
  localparam int unsigned N_CHUNKS = DIMENSION / LANES;
  localparam int unsigned K_W      = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(N_CHUNKS - 1);

  localparam logic signed [ACC_WIDTH-1:0] NARROW_MAX = ACC_WIDTH'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] NARROW_MIN = ACC_WIDTH'(-(2 ** (WIDTH - 1)));
  localparam logic signed [WIDTH-1:0]     VV_MAX     = {1'b0, {(WIDTH - 1){1'b1}}};
  localparam logic signed [WIDTH-1:0]     VV_MIN     = {1'b1, {(WIDTH - 1){1'b0}}};

  if (LANES == 0) begin : g_chk_lanes_zero
    $error("LANES must be at least 1");
  end
  if ((DIMENSION % LANES) != 0) begin : g_chk_lanes_div
    $error("DIMENSION must be an integer multiple of LANES");
  end
  if (ACC_WIDTH < 2 * WIDTH + $clog2(DIMENSION)) begin : g_chk_acc
    $error("ACC_WIDTH too small for a wrap-free accumulation");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                       state;
  logic [K_W-1:0]               k;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic [VEC_W-1:0]             v1_q;
  logic [VEC_W-1:0]             v2_q;

  logic signed [WIDTH-1:0]      a_c;
  logic signed [WIDTH-1:0]      b_c;
  logic signed [2*WIDTH-1:0]    prod_c;
  logic signed [ACC_WIDTH-1:0]  lane_sum_c;
  logic signed [ACC_WIDTH-1:0]  acc_next_c;
  logic signed [ACC_WIDTH-1:0]  shifted_c;
  logic signed [WIDTH-1:0]      vv_c;
  logic                         sat_c;

  // Operands shift down one chunk per RUN cycle, so the lanes always read the low chunk.
  always_comb begin
    a_c        = '0;
    b_c        = '0;
    prod_c     = '0;
    lane_sum_c = '0;
    for (int j = 0; j < int'(LANES); j++) begin
      a_c        = v1_q[j*WIDTH +: WIDTH];
      b_c        = v2_q[j*WIDTH +: WIDTH];
      prod_c     = (2*WIDTH)'(a_c) * (2*WIDTH)'(b_c);
      lane_sum_c = lane_sum_c + ACC_WIDTH'(prod_c);
    end
  end

  // Final accumulate, floor shift and signed clip to the narrow result.
  always_comb begin
    acc_next_c = acc + lane_sum_c;
    shifted_c  = acc_next_c >>> OUT_SHIFT;
    sat_c      = 1'b0;
    vv_c       = shifted_c[WIDTH-1:0];
    if (shifted_c > NARROW_MAX) begin
      sat_c = 1'b1;
      vv_c  = VV_MAX;
    end else if (shifted_c < NARROW_MIN) begin
      sat_c = 1'b1;
      vv_c  = VV_MIN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      acc         <= '0;
      v1_q        <= '0;
      v2_q        <= '0;
      bus.ready   <= 1'b1;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.VV      <= '0;
      bus.VV_full <= '0;
      bus.sat     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state     <= RUN;
            v1_q      <= bus.V1;
            v2_q      <= bus.V2;
            acc       <= '0;
            k         <= '0;
            bus.ready <= 1'b0;
            bus.busy  <= 1'b1;
          end else begin
            state     <= IDLE;
            bus.ready <= 1'b1;
            bus.busy  <= 1'b0;
          end
        end
        RUN: begin
          acc  <= acc_next_c;
          v1_q <= v1_q >> CHUNK_W;
          v2_q <= v2_q >> CHUNK_W;
          if (k == K_LAST) begin
            state       <= DONE;
            bus.ready   <= 1'b1;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            bus.VV_full <= acc_next_c;
            bus.VV      <= vv_c;
            bus.sat     <= sat_c;
          end else begin
            k <= k + K_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
          bus.busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_dot_lanes.sv
// Scoreboard bench: drivers push expected results, per-DUT monitors pop and compare on done.
module tb_vec_dot_lanes;

  localparam int unsigned DIM = 16;
  localparam int unsigned W   = 8;
  localparam int unsigned AW  = 20;

  typedef struct {
    logic signed [AW-1:0] full;
    logic signed [W-1:0]  vv;
    logic                 sat;
    int                   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t qd[$];

  vec_dot_lanes_if #(.DIMENSION(DIM), .WIDTH(W), .ACC_WIDTH(AW)) ifa ();
  vec_dot_lanes_if #(.DIMENSION(DIM), .WIDTH(W), .ACC_WIDTH(AW)) ifb ();
  vec_dot_lanes_if #(.DIMENSION(DIM), .WIDTH(W), .ACC_WIDTH(AW)) ifc ();
  vec_dot_lanes_if #(.DIMENSION(DIM), .WIDTH(W), .ACC_WIDTH(AW)) ifd ();

  vec_dot_lanes #(.DIMENSION(DIM), .WIDTH(W), .LANES(4),  .ACC_WIDTH(AW), .OUT_SHIFT(0))
    dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  vec_dot_lanes #(.DIMENSION(DIM), .WIDTH(W), .LANES(1),  .ACC_WIDTH(AW), .OUT_SHIFT(0))
    dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  vec_dot_lanes #(.DIMENSION(DIM), .WIDTH(W), .LANES(16), .ACC_WIDTH(AW), .OUT_SHIFT(0))
    dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));
  vec_dot_lanes #(.DIMENSION(DIM), .WIDTH(W), .LANES(4),  .ACC_WIDTH(AW), .OUT_SHIFT(4))
    dut_d (.clk(clk), .rst(rst), .bus(ifd.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [DIM*W-1:0] fill(input int v);
    logic [DIM*W-1:0] r;
    for (int i = 0; i < int'(DIM); i++) r[i*W +: W] = W'(v);
    return r;
  endfunction

  function automatic logic [DIM*W-1:0] ramp(input int off);
    logic [DIM*W-1:0] r;
    for (int i = 0; i < int'(DIM); i++) r[i*W +: W] = W'(i + off);
    return r;
  endfunction

  function automatic logic [DIM*W-1:0] one(input int v);
    logic [DIM*W-1:0] r;
    r = '0;
    r[W-1:0] = W'(v);
    return r;
  endfunction

  task automatic chk(input string nm, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", nm, got, expv, cyc);
    end
  endtask

  task automatic score(input string nm, input exp_t e, input logic signed [AW-1:0] f,
                       input logic signed [W-1:0] v, input logic s);
    chk({nm, "_full"}, int'(f), int'(e.full));
    chk({nm, "_vv"}, int'(v), int'(e.vv));
    chk({nm, "_sat"}, int'(s), int'(e.sat));
    chk({nm, "_done_cycle"}, cyc, e.cyc);
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s_unexpected_done got done=1 expected no done (cycle %0d)", nm, cyc);
  endtask

  always @(negedge clk) if (ifa.done === 1'b1) begin
    if (qa.size() == 0) unexpected("a");
    else score("a", qa.pop_front(), ifa.VV_full, ifa.VV, ifa.sat);
  end
  always @(negedge clk) if (ifb.done === 1'b1) begin
    if (qb.size() == 0) unexpected("b");
    else score("b", qb.pop_front(), ifb.VV_full, ifb.VV, ifb.sat);
  end
  always @(negedge clk) if (ifc.done === 1'b1) begin
    if (qc.size() == 0) unexpected("c");
    else score("c", qc.pop_front(), ifc.VV_full, ifc.VV, ifc.sat);
  end
  always @(negedge clk) if (ifd.done === 1'b1) begin
    if (qd.size() == 0) unexpected("d");
    else score("d", qd.pop_front(), ifd.VV_full, ifd.VV, ifd.sat);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int d);
    case (d)
      0: return ifa.ready;
      1: return ifb.ready;
      2: return ifc.ready;
      default: return ifd.ready;
    endcase
  endfunction

  task automatic drive(input int d, input logic st, input logic [DIM*W-1:0] a, input logic [DIM*W-1:0] b);
    case (d)
      0: begin ifa.start = st; ifa.V1 = a; ifa.V2 = b; end
      1: begin ifb.start = st; ifb.V1 = a; ifb.V2 = b; end
      2: begin ifc.start = st; ifc.V1 = a; ifc.V2 = b; end
      default: begin ifd.start = st; ifd.V1 = a; ifd.V2 = b; end
    endcase
  endtask

  // Called #1 after an edge; returns #1 after the accepting edge (first RUN cycle).
  task automatic start_op(input int d, input int n, input logic [DIM*W-1:0] a, input logic [DIM*W-1:0] b,
                          input bit push, input int full, input int vv, input logic s);
    exp_t e;
    int   w;
    w = 0;
    while (rdy(d) !== 1'b1 && w < 60) begin
      tick();
      w++;
    end
    if (w >= 60) chk("ready_wait_timeout", 0, 1);
    e.full = AW'(full);
    e.vv   = W'(vv);
    e.sat  = s;
    e.cyc  = cyc + n + 1;
    drive(d, 1'b1, a, b);
    if (push) begin
      case (d)
        0: qa.push_back(e);
        1: qb.push_back(e);
        2: qc.push_back(e);
        default: qd.push_back(e);
      endcase
    end
    tick();
    drive(d, 1'b0, a, b);
  endtask

  initial begin
    int s;
    for (int d = 0; d < 4; d++) drive(d, 1'b0, '0, '0);
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_ready", int'(ifa.ready), 1);
    chk("rst_busy", int'(ifa.busy), 0);
    chk("rst_done", int'(ifa.done), 0);
    chk("rst_vv_full", int'(ifa.VV_full), 0);
    chk("rst_vv", int'(ifa.VV), 0);
    chk("rst_sat", int'(ifa.sat), 0);
    rst = 1'b0;
    tick();

    // All-ones with explicit busy/ready timing.
    s = cyc;
    start_op(0, 4, fill(1), fill(1), 1, 16, 16, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("a_busy_run", int'(ifa.busy), 1);
      chk("a_ready_run", int'(ifa.ready), 0);
      tick();
    end
    chk("a_busy_done", int'(ifa.busy), 0);
    chk("a_ready_done", int'(ifa.ready), 1);
    chk("a_done_at_s_plus_5", cyc, s + 5);
    repeat (3) tick();

    start_op(0, 4, ramp(0),   fill(1),    1, 120,     120,  1'b0); repeat (8) tick();
    start_op(0, 4, fill(-128), fill(-128), 1, 262144,  127,  1'b1); repeat (8) tick();
    start_op(0, 4, fill(-128), fill(127),  1, -260096, -128, 1'b1); repeat (8) tick();
    start_op(0, 4, ramp(-8),  ramp(0),    1, 280,     127,  1'b1); repeat (8) tick();
    start_op(0, 4, fill(-1),  ramp(0),    1, -120,    -120, 1'b0); repeat (8) tick();
    start_op(0, 4, one(127),  one(1),     1, 127,     127,  1'b0); repeat (8) tick();
    start_op(0, 4, one(64),   one(2),     1, 128,     127,  1'b1); repeat (8) tick();
    start_op(0, 4, one(-128), one(1),     1, -128,    -128, 1'b0); repeat (8) tick();
    start_op(0, 4, one(-43),  one(3),     1, -129,    -128, 1'b1); repeat (8) tick();

    // start and operand changes during RUN are ignored; restart straight from DONE.
    s = cyc;
    start_op(0, 4, fill(1), fill(1), 1, 16, 16, 1'b0);
    drive(0, 1'b1, fill(5), fill(7));
    tick();
    tick();
    drive(0, 1'b0, fill(9), fill(9));
    while (cyc < s + 5) tick();
    start_op(0, 4, ramp(0), fill(1), 1, 120, 120, 1'b0);
    repeat (8) tick();

    // Reset in RUN cycle 2 discards the operation.
    start_op(0, 4, fill(2), fill(2), 0, 0, 0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", int'(ifa.ready), 1);
    chk("midrst_busy", int'(ifa.busy), 0);
    chk("midrst_done", int'(ifa.done), 0);
    chk("midrst_vv_full", int'(ifa.VV_full), 0);
    chk("midrst_vv", int'(ifa.VV), 0);
    chk("midrst_sat", int'(ifa.sat), 0);
    repeat (8) tick();
    start_op(0, 4, fill(1), fill(1), 1, 16, 16, 1'b0);
    repeat (8) tick();

    // Fully serial and fully parallel lane counts.
    start_op(1, 16, ramp(0), fill(1), 1, 120, 120, 1'b0); repeat (20) tick();
    start_op(2, 1,  ramp(0), fill(1), 1, 120, 120, 1'b0); repeat (5) tick();
    start_op(2, 1,  fill(-1), ramp(0), 1, -120, -120, 1'b0); repeat (5) tick();

    // OUT_SHIFT=4: floor shift and clip.
    start_op(3, 4, fill(3),    fill(3),    1, 144,    9,   1'b0); repeat (8) tick();
    start_op(3, 4, fill(-1),   fill(1),    1, -16,    -1,  1'b0); repeat (8) tick();
    start_op(3, 4, one(-17),   one(1),     1, -17,    -2,  1'b0); repeat (8) tick();
    start_op(3, 4, fill(-128), fill(-128), 1, 262144, 127, 1'b1); repeat (8) tick();

    repeat (10) tick();
    chk("a_pending", qa.size(), 0);
    chk("b_pending", qb.size(), 0);
    chk("c_pending", qc.size(), 0);
    chk("d_pending", qd.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
